// File: rtl/wbu.sv
// rtl/wbu.sv - write-back stage: data select, 2-entry FIFO, GPR write port, retire counter
// Optional WBU_DIFFTEST_EN adds per-entry PC storage and commit outputs.
module wbu #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_lsu_valid,
  output logic                    o_sys_ready,
  input  logic [DATA_WIDTH-1:0]   i_lsu_gpr_wr_data,
  input  logic [DATA_WIDTH-1:0]   i_exu_res,
  input  logic [ADDR_WIDTH-1:0]   i_pc,
  input  logic                    i_idu_ctr_reg_wr_en,
  input  logic [1:0]              i_idu_ctr_reg_wr_src,
  input  logic [REG_ID_WIDTH-1:0] i_idu_rd_id,
  input  logic                    i_gpr_wr_ready,
  output logic                    o_wbu_gpr_wr_en,
  output logic [REG_ID_WIDTH-1:0] o_wbu_gpr_wr_id,
  output logic [DATA_WIDTH-1:0]   o_wbu_gpr_wr_data,
  output logic                    o_wbu_fwd_valid,
  output logic [CNT_WIDTH-1:0]    o_wbu_retire_cnt
`ifdef WBU_DIFFTEST_EN
  ,
  output logic                    o_wbu_cmt_valid,
  output logic [ADDR_WIDTH-1:0]   o_wbu_cmt_pc,
  output logic [DATA_WIDTH-1:0]   o_wbu_cmt_data
`endif
);

  localparam int EXT_W = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;

  logic [1:0]              count;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [DATA_WIDTH-1:0]   ent_data [2];
  logic [REG_ID_WIDTH-1:0] ent_rd   [2];
  logic                    ent_wen  [2];
`ifdef WBU_DIFFTEST_EN
  logic [ADDR_WIDTH-1:0]   ent_pc   [2];
`endif

  logic                    head_valid;
  logic                    enq;
  logic                    deq;
  logic [ADDR_WIDTH-1:0]   pc_plus4;
  logic [EXT_W-1:0]        pc4_ext;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_wen;

  assign head_valid  = (count != 2'd0);
  assign o_sys_ready = (count < 2'd2);
  assign enq         = i_lsu_valid && o_sys_ready;
  // Entries that do not write a register drain without waiting for the GPR port.
  assign deq         = head_valid && (i_gpr_wr_ready || !ent_wen[rd_ptr]);

  assign pc_plus4 = i_pc + ADDR_WIDTH'(4);
  assign pc4_ext  = EXT_W'(pc_plus4);
  assign sel_wen  = i_idu_ctr_reg_wr_en && (i_idu_rd_id != '0);

  always_comb begin
    sel_data = i_exu_res;
    case (i_idu_ctr_reg_wr_src)
      2'b01:   sel_data = i_lsu_gpr_wr_data;
      2'b10:   sel_data = pc4_ext[DATA_WIDTH-1:0];
      default: sel_data = i_exu_res;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count            <= 2'd0;
      wr_ptr           <= 1'b0;
      rd_ptr           <= 1'b0;
      o_wbu_retire_cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        ent_data[i] <= '0;
        ent_rd[i]   <= '0;
        ent_wen[i]  <= 1'b0;
`ifdef WBU_DIFFTEST_EN
        ent_pc[i]   <= '0;
`endif
      end
    end else begin
      if (enq) begin
        ent_data[wr_ptr] <= sel_data;
        ent_rd[wr_ptr]   <= i_idu_rd_id;
        ent_wen[wr_ptr]  <= sel_wen;
`ifdef WBU_DIFFTEST_EN
        ent_pc[wr_ptr]   <= i_pc;
`endif
        wr_ptr <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr           <= ~rd_ptr;
        o_wbu_retire_cnt <= o_wbu_retire_cnt + CNT_WIDTH'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign o_wbu_gpr_wr_en   = head_valid && ent_wen[rd_ptr];
  assign o_wbu_gpr_wr_id   = head_valid ? ent_rd[rd_ptr]   : '0;
  assign o_wbu_gpr_wr_data = head_valid ? ent_data[rd_ptr] : '0;
  assign o_wbu_fwd_valid   = o_wbu_gpr_wr_en;

`ifdef WBU_DIFFTEST_EN
  assign o_wbu_cmt_valid = deq;
  assign o_wbu_cmt_pc    = head_valid ? ent_pc[rd_ptr]   : '0;
  assign o_wbu_cmt_data  = head_valid ? ent_data[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_wbu.sv
// tb/tb_wbu.sv - directed self-checking bench for wbu
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        sys_ready;
  logic [31:0] lsu_data = '0;
  logic [31:0] exu_res = '0;
  logic [31:0] pc = '0;
  logic        wr_en_in = 1'b0;
  logic [1:0]  wr_src = 2'b00;
  logic [4:0]  rd_id = '0;
  logic        gpr_ready = 1'b0;
  logic        gpr_wr_en;
  logic [4:0]  gpr_wr_id;
  logic [31:0] gpr_wr_data;
  logic        fwd_valid;
  logic [63:0] retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  wbu dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_lsu_valid          (lsu_valid),
    .o_sys_ready          (sys_ready),
    .i_lsu_gpr_wr_data    (lsu_data),
    .i_exu_res            (exu_res),
    .i_pc                 (pc),
    .i_idu_ctr_reg_wr_en  (wr_en_in),
    .i_idu_ctr_reg_wr_src (wr_src),
    .i_idu_rd_id          (rd_id),
    .i_gpr_wr_ready       (gpr_ready),
    .o_wbu_gpr_wr_en      (gpr_wr_en),
    .o_wbu_gpr_wr_id      (gpr_wr_id),
    .o_wbu_gpr_wr_data    (gpr_wr_data),
    .o_wbu_fwd_valid      (fwd_valid),
    .o_wbu_retire_cnt     (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] src, input logic [4:0] rd,
                       input logic [31:0] ex, input logic [31:0] ld, input logic [31:0] p);
    lsu_valid = v;
    wr_en_in  = 1'b1;
    wr_src    = src;
    rd_id     = rd;
    exu_res   = ex;
    lsu_data  = ld;
    pc        = p;
  endtask

  initial begin
    #2;
    check("rst_ready", sys_ready, 1);
    check("rst_wr_en", gpr_wr_en, 0);
    check("rst_cnt", retire_cnt, 0);
    tick();
    rst = 1'b0;

    // load data, rd=5
    gpr_ready = 1'b1;
    drive(1, 2'b01, 5'd5, 32'h0, 32'hFFFF_FF80, 32'h0);
    tick();
    check("ld_wr_en", gpr_wr_en, 1);
    check("ld_wr_id", gpr_wr_id, 5);
    check("ld_wr_data", gpr_wr_data, 32'hFFFF_FF80);
    check("ld_fwd", fwd_valid, 1);
    check("ld_cnt_before", retire_cnt, 0);
    lsu_valid = 1'b0;
    tick();
    check("ld_cnt_after", retire_cnt, 1);
    check("ld_drained", gpr_wr_en, 0);

    // pc+4 select, including wrap
    drive(1, 2'b10, 5'd1, 32'h0, 32'h0, 32'h8000_0FFC);
    tick();
    check("pc4_data", gpr_wr_data, 32'h8000_1000);
    check("pc4_id", gpr_wr_id, 1);
    drive(1, 2'b10, 5'd1, 32'h0, 32'h0, 32'hFFFF_FFFC);
    tick();
    check("pc4_wrap_data", gpr_wr_data, 32'h0);
    check("pc4_wrap_en", gpr_wr_en, 1);
    check("pc4_cnt", retire_cnt, 2);
    lsu_valid = 1'b0;
    tick();
    check("pc4_cnt2", retire_cnt, 3);

    // rd=x0 retires without GPR ready and without a write
    gpr_ready = 1'b0;
    drive(1, 2'b00, 5'd0, 32'h1234, 32'h0, 32'h0);
    tick();
    check("x0_wr_en", gpr_wr_en, 0);
    check("x0_fwd", fwd_valid, 0);
    lsu_valid = 1'b0;
    tick();
    check("x0_cnt", retire_cnt, 4);
    check("x0_ready", sys_ready, 1);

    // back-pressure: three writes, only two accepted
    drive(1, 2'b00, 5'd10, 32'hA, 32'h0, 32'h0);
    tick();
    check("bp1_id", gpr_wr_id, 10);
    check("bp1_ready", sys_ready, 1);
    drive(1, 2'b00, 5'd11, 32'hB, 32'h0, 32'h0);
    tick();
    check("bp2_ready", sys_ready, 0);
    drive(1, 2'b00, 5'd12, 32'hC, 32'h0, 32'h0);
    tick();
    check("bp3_ready", sys_ready, 0);
    check("bp3_id", gpr_wr_id, 10);
    check("bp3_cnt", retire_cnt, 4);

    // full with ready: dequeue only, no pass-through enqueue
    gpr_ready = 1'b1;
    tick();
    check("full_deq_id", gpr_wr_id, 11);
    check("full_deq_data", gpr_wr_data, 32'hB);
    check("full_deq_ready", sys_ready, 1);
    check("full_deq_cnt", retire_cnt, 5);
    tick();
    check("ord3_id", gpr_wr_id, 12);
    check("ord3_data", gpr_wr_data, 32'hC);
    check("ord3_ready", sys_ready, 1);
    check("ord3_cnt", retire_cnt, 6);
    lsu_valid = 1'b0;
    tick();
    check("ord_end_en", gpr_wr_en, 0);
    check("ord_end_cnt", retire_cnt, 7);

    // asynchronous reset mid-cycle discards buffered entries
    gpr_ready = 1'b0;
    drive(1, 2'b00, 5'd7, 32'h77, 32'h0, 32'h0);
    tick();
    drive(1, 2'b00, 5'd8, 32'h88, 32'h0, 32'h0);
    tick();
    lsu_valid = 1'b0;
    check("pre_rst_ready", sys_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wr_en", gpr_wr_en, 0);
    check("arst_id", gpr_wr_id, 0);
    check("arst_data", gpr_wr_data, 0);
    check("arst_fwd", fwd_valid, 0);
    check("arst_ready", sys_ready, 1);
    check("arst_cnt", retire_cnt, 0);
    tick();
    rst = 1'b0;
    gpr_ready = 1'b1;
    tick();
    check("post_rst_en", gpr_wr_en, 0);
    check("post_rst_cnt", retire_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
